mic_trigger_decimator: RTL
==========================

# mic_trigger_decimator

Front-end conditioning stage between the microphone sampler and the waveform display. Averages raw 12-bit mic samples by a selectable power-of-two factor, then uses a rising-edge trigger state machine to release stable 96-sample frames, one sample per `sample_valid` pulse. The display stage consumes the frames into its history buffer. A per-frame peak value is also reported for volume indicators.

## Interface
- `FRAME_LEN`, 96: samples per released frame; equals the display width.
- `TRIG_LEVEL`, 2048: trigger threshold in 12-bit sample units.
- `HOLDOFF`, 32: decimated samples ignored after a frame before re-arming.
- `TIMEOUT`, 192: decimated samples in ARM before auto-trigger (see Configuration).
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_en` in 1: one-`clk` strobe at the mic sample rate (20 kHz).
- `mic_in` in 12: raw unsigned mic sample; valid while `sample_en` is high.
- `decim_sel` in 2: averaging factor 2^`decim_sel` (1, 2, 4 or 8).
- `pause_switch` in 1: 1 blocks new triggers.
- `sample_out` out 12: decimated sample; valid with `sample_valid`.
- `sample_valid` out 1: one-`clk` pulse per released frame sample.
- `frame_start` out 1: high together with `sample_valid` on the first sample of a frame.
- `peak_out` out 12: maximum `sample_out` of the last completed frame.
- `armed` out 1: high in the ARM state.

## Operation
- **Decimator:**
  - 15-bit accumulator plus a 3-bit group counter.
  - Each `sample_en` adds `mic_in`.
  - On the 2^N-th sample of a group, `avg = (acc + mic_in) >> N`; the accumulator and counter clear.
  - `decim_sel` is latched only when a group starts, so a mid-group change takes effect at the next group.
  - Every `avg` result is called a decimated sample (DS).
- **Trigger FSM:** four states, ARM, CAPTURE, HOLD, IDLE.
  - Reset state is IDLE. IDLE moves to ARM on the first DS when `pause_switch`=0.
  - ARM goes to CAPTURE on a rising crossing: previous DS < `TRIG_LEVEL` and current DS >= `TRIG_LEVEL`. The crossing DS is emitted as sample 0 with `frame_start`.
  - CAPTURE emits every DS. After the `FRAME_LEN`-th sample it goes to HOLD and loads `peak_out`.
  - HOLD discards `HOLDOFF` DS, then goes to ARM, or to IDLE if `pause_switch`=1.
  - ARM with `pause_switch`=1 goes to IDLE on the next DS.
  - `pause_switch` never truncates a frame in CAPTURE.
- **Previous DS register:** reset value 0xFFF, so no false trigger on the first DS.
- **Peak tracker:** the running max is cleared at `frame_start` and includes sample 0. It is copied to `peak_out` when the last sample is emitted.
- **Counters:**
  - Frame count 7 bits, wraps 95→0 at the CAPTURE exit.
  - Holdoff and timeout counts are 8 bits and saturate at their limits.

## Timing
- **Reset values:** `sample_out`=0, `sample_valid`=0, `frame_start`=0, `peak_out`=0, `armed`=0; accumulator, counters and FSM are cleared to IDLE.
- **Latency:** `sample_valid` rises exactly one `clk` after the `sample_en` that completes a group. `sample_out` is registered in that same cycle and held until the next pulse.
- **Pulse spacing:** at most one `sample_valid` per group; pulses are never back-to-back unless `sample_en` is held high continuously.
- `armed` is registered and updates one `clk` after the state transition.
- **Reset mid-frame:** the frame is abandoned with no further pulses, `peak_out` is cleared, and the partial group is discarded.
- **Full-scale input:** 8×0xFFF = 0x7FF8 fits in 15 bits; no overflow.

## Configuration
- `MIC_TRIG_AUTO_EN` defined:
  - ARM counts DS; when the count reaches `TIMEOUT` with no crossing, the FSM enters CAPTURE using the current DS as sample 0 (free-run display for DC or silence).
  - The count resets on entry to ARM.
- Undefined: ARM waits indefinitely for a crossing; the timeout counter is not built.

## Test plan
- **Decimation:** `decim_sel`=2 with `mic_in`=100,200,300,400 on 4 strobes → DS 250, `sample_valid` one `clk` after the 4th strobe.
- **Triggered frame:** `decim_sel`=0 with a ramp 2040,2044,2048,… → `frame_start` on sample 2048, then exactly 96 pulses. `peak_out`=2048+95·4=2428 after the last pulse; 32 DS are discarded, then `armed`=1.
- **Pause:** `pause_switch` raised at capture sample 40 → remaining 55 samples still emitted; after holdoff the FSM enters IDLE and `armed`=0. No pulses until pause drops and a crossing occurs.
- **Auto-trigger:** constant `mic_in`=1000 with `MIC_TRIG_AUTO_EN` → `frame_start` on the 192nd DS after entering ARM. Without the macro, no `sample_valid` after 1000 DS.
- **Mid-operation reset:** `reset` at capture sample 10 → outputs zero next `clk`; the first DS after reset (any value, e.g. 3000) does not trigger.
- **Full-scale:** `decim_sel`=3, 8×0xFFF → `sample_out`=0xFFF; `peak_out`=0xFFF at frame end.

Source files
------------

// File: rtl/mic_trigger_decimator.sv
// Power-of-two averaging of 12-bit mic samples feeding a rising-edge trigger FSM that releases frames; MIC_TRIG_AUTO_EN adds an ARM timeout auto-trigger.
// Latency: sample_valid one clk after the group-completing sample_en; no backpressure, the consumer takes every pulse.
module mic_trigger_decimator #(
  parameter int unsigned FRAME_LEN  = 96,
  parameter int unsigned TRIG_LEVEL = 2048,
  parameter int unsigned HOLDOFF    = 32,
  parameter int unsigned TIMEOUT    = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [11:0] mic_in,
  input  logic [1:0]  decim_sel,
  input  logic        pause_switch,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  output logic        frame_start,
  output logic [11:0] peak_out,
  output logic        armed
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, HOLD} state_t;

  localparam logic [11:0] TRIG       = 12'(TRIG_LEVEL);
  localparam logic [6:0]  FRAME_LAST = 7'(FRAME_LEN - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLDOFF - 1);

  state_t      state;
  state_t      state_nxt;

  logic [14:0] acc;
  logic [2:0]  grp_cnt;
  logic [1:0]  grp_sel;
  logic [1:0]  sel;
  logic [14:0] sum;
  logic [2:0]  grp_last;
  logic        ds_vld;
  logic [11:0] ds;

  logic [11:0] prev_ds;
  logic [11:0] run_peak;
  logic [11:0] peak_max;
  logic [6:0]  frm_cnt;
  logic [7:0]  hold_cnt;
  logic        crossing;
  logic        auto_fire;
  logic        emit;
  logic        emit_first;
  logic        frame_done;

  // The factor is taken from decim_sel only on the first sample of a group.
  always_comb begin
    sel      = (grp_cnt == 3'd0) ? decim_sel : grp_sel;
    sum      = acc + {3'b000, mic_in};
    grp_last = 3'((4'd1 << sel) - 4'd1);
    ds_vld   = sample_en && (grp_cnt == grp_last);
    ds       = 12'(sum >> sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      grp_cnt <= '0;
      grp_sel <= '0;
    end else if (sample_en) begin
      grp_sel <= sel;
      if (ds_vld) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= sum;
        grp_cnt <= grp_cnt + 3'd1;
      end
    end
  end

  assign crossing = (prev_ds < TRIG) && (ds >= TRIG);
  assign peak_max = (ds > run_peak) ? ds : run_peak;

`ifdef MIC_TRIG_AUTO_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;

  assign auto_fire = (to_cnt == TO_LAST);

  // Held at zero outside ARM so it always starts fresh on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (ds_vld) begin
      if (state != ARM) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every transition is paced by a decimated sample.
  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    emit_first = 1'b0;
    frame_done = 1'b0;
    if (ds_vld) begin
      case (state)
        IDLE: begin
          if (!pause_switch) state_nxt = ARM;
        end
        ARM: begin
          if (pause_switch) begin
            state_nxt = IDLE;
          end else if (crossing || auto_fire) begin
            state_nxt  = CAPTURE;
            emit       = 1'b1;
            emit_first = 1'b1;
          end
        end
        CAPTURE: begin
          emit = 1'b1;
          if (frm_cnt == FRAME_LAST) begin
            frame_done = 1'b1;
            state_nxt  = HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) state_nxt = pause_switch ? IDLE : ARM;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_ds  <= 12'hFFF;
      run_peak <= '0;
      frm_cnt  <= '0;
      hold_cnt <= '0;
    end else if (ds_vld) begin
      prev_ds <= ds;
      if (emit_first) begin
        frm_cnt  <= 7'd1;
        run_peak <= ds;
      end else if (frame_done) begin
        frm_cnt <= '0;
      end else if (emit) begin
        frm_cnt  <= frm_cnt + 7'd1;
        run_peak <= peak_max;
      end
      if (frame_done) begin
        hold_cnt <= '0;
      end else if (state == HOLD && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      peak_out     <= '0;
      armed        <= 1'b0;
    end else begin
      sample_valid <= emit;
      frame_start  <= emit_first;
      armed        <= (state == ARM);
      if (emit) sample_out <= ds;
      if (frame_done) peak_out <= peak_max;
    end
  end

endmodule
